// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state and op encodings for the iterative mult/div unit.
package multdiv_pkg;
  typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_BAD} op_t;
endpackage

// File: rtl/multdiv_signfix.sv
// multdiv_signfix: conditional two's-complement negate, used for operand abs-value and result sign fix-up.
module multdiv_signfix #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);
  assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative shift-add multiplier / restoring divider with ready/busy handshake and exceptions.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_inputRDY,
  output logic             data_resultRDY
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  state_t r_state, w_next_state;
  op_t r_op, w_op;
  logic [2*W-1:0] r_acc, w_acc_next, w_fix_in, w_fix;
  logic [W:0] r_mc, w_abs_a, w_abs_b, w_sum, w_rsh;
  logic [W-1:0] r_result, w_rem;
  logic [CW-1:0] r_cnt;
  logic r_exc, r_neg, w_sa, w_sb, w_start, w_busy, w_done, w_ge, w_mexc, w_dexc;
  // Magnitudes are W+1 bits so |MIN_INT| is representable.
  assign w_sa = SIGNED & data_operandA[W-1];
  assign w_sb = SIGNED & data_operandB[W-1];
  multdiv_signfix #(.W(W+1)) u_abs_a (.i_val({w_sa, data_operandA}), .i_neg(w_sa), .o_val(w_abs_a));
  multdiv_signfix #(.W(W+1)) u_abs_b (.i_val({w_sb, data_operandB}), .i_neg(w_sb), .o_val(w_abs_b));
  assign data_inputRDY  = r_state == IDLE || r_state == FIN;
  assign data_resultRDY = r_state == FIN;
  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign w_start = data_inputRDY & (ctrl_MULT | ctrl_DIV);
  assign w_op = (ctrl_MULT & ctrl_DIV) || (ctrl_DIV && data_operandB == '0) ? OP_BAD :
                ctrl_MULT ? OP_MUL : OP_DIV;
  assign w_busy = r_state == MULT || r_state == DIV;
  assign w_done = r_cnt == CW'(W);
  // Multiply: add multiplicand into upper half when the low multiplier bit is set, then shift right.
  assign w_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? r_mc : '0);
  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  assign w_rsh = r_acc[2*W-1:W-1];
  assign w_ge  = w_rsh >= r_mc;
  assign w_rem = W'(w_ge ? w_rsh - r_mc : w_rsh);
  assign w_acc_next = r_op == OP_DIV ? {w_rem, r_acc[W-2:0], w_ge} : {w_sum, r_acc[W-1:1]};
  assign w_fix_in = r_op == OP_DIV ? {{W{1'b0}}, r_acc[W-1:0]} : r_acc;
  multdiv_signfix #(.W(2*W)) u_fix (.i_val(w_fix_in), .i_neg(r_neg), .o_val(w_fix));
  assign w_mexc = SIGNED ? !(&w_fix[2*W-1:W-1] || ~|w_fix[2*W-1:W-1]) : |w_fix[2*W-1:W];
  // Only MIN_INT / -1 yields a positive quotient magnitude with the top bit set.
  assign w_dexc = SIGNED & ~r_neg & r_acc[W-1];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next_state;
  always_comb begin
    w_next_state = r_state;
    if (data_inputRDY) w_next_state = w_start ? (w_op == OP_MUL ? MULT : DIV) : IDLE;
    else if (w_done) w_next_state = FIN;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_mc     <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      r_op  <= w_op;
      r_neg <= SIGNED & (data_operandA[W-1] ^ data_operandB[W-1]);
      r_cnt <= w_op == OP_BAD ? CW'(W) : '0;
      r_mc  <= w_op == OP_MUL ? w_abs_a : w_abs_b;
      r_acc <= {{(W-1){1'b0}}, w_op == OP_MUL ? w_abs_b : w_abs_a};
    end else if (w_busy) begin
      if (w_done) begin
        r_result <= r_op == OP_BAD ? '0 : w_fix[W-1:0];
        r_exc    <= r_op == OP_BAD || (r_op == OP_MUL ? w_mexc : w_dexc);
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CW'(1);
      end
    end
endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: randomized + directed check of signed and unsigned multdiv_iter against an arithmetic model.
module tb_multdiv_iter;
  logic clk = 1'b0, rst_n = 1'b0, cm = 1'b0, cd = 1'b0, chk_on = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] s_res, u_res;
  logic s_exc, s_ir, s_rr, u_exc, u_ir, u_rr;
  int n_chk = 0, n_fail = 0;
  int m_left = -1;
  bit m_fin = 0, m_es = 0, m_eu = 0, p_es, p_eu;
  logic [31:0] m_rs = '0, m_ru = '0, p_rs, p_ru;
  int p_lat;

  always #5 clk = ~clk;

  multdiv_iter #(.WIDTH(32), .SIGNED(1'b1)) u_s (
    .clock(clk), .reset_n(rst_n), .data_operandA(a), .data_operandB(b),
    .ctrl_MULT(cm), .ctrl_DIV(cd), .data_result(s_res), .data_exception(s_exc),
    .data_inputRDY(s_ir), .data_resultRDY(s_rr));
  multdiv_iter #(.WIDTH(32), .SIGNED(1'b0)) u_u (
    .clock(clk), .reset_n(rst_n), .data_operandA(a), .data_operandB(b),
    .ctrl_MULT(cm), .ctrl_DIV(cd), .data_result(u_res), .data_exception(u_exc),
    .data_inputRDY(u_ir), .data_resultRDY(u_rr));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] ia, input logic [31:0] ib, input bit mul,
                                input bit dv, output logic [31:0] rs, output bit es,
                                output logic [31:0] ru, output bit eu, output int lat);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    logic [31:0] lo;
    sa = $signed(ia); sb = $signed(ib); ua = ia; ub = ib;
    lat = 33;
    if ((mul && dv) || (dv && ib == 0)) begin
      rs = 0; es = 1; ru = 0; eu = 1; lat = 1;
    end else if (mul) begin
      p = sa * sb; lo = p[31:0]; rs = lo; es = p != longint'($signed(lo));
      up = ua * ub; ru = up[31:0]; eu = (up >> 32) != 0;
    end else begin
      if (ia == 32'h8000_0000 && ib == 32'hFFFF_FFFF) begin
        rs = ia; es = 1;
      end else begin
        p = sa / sb; rs = p[31:0]; es = 0;
      end
      ru = ia / ib; eu = 0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = -1; m_fin = 0; m_rs = '0; m_es = 0; m_ru = '0; m_eu = 0;
    end else begin
      m_fin = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_left = -1; m_fin = 1;
          m_rs = p_rs; m_es = p_es; m_ru = p_ru; m_eu = p_eu;
        end
      end else if (cm || cd) begin
        model(a, b, cm, cd, p_rs, p_es, p_ru, p_eu, p_lat);
        m_left = p_lat;
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("s_inputRDY", 64'(s_ir), 64'(m_left < 0));
    chk("s_resultRDY", 64'(s_rr), 64'(m_fin));
    chk("s_result", 64'(s_res), 64'(m_rs));
    chk("s_exception", 64'(s_exc), 64'(m_es));
    chk("u_inputRDY", 64'(u_ir), 64'(m_left < 0));
    chk("u_resultRDY", 64'(u_rr), 64'(m_fin));
    chk("u_result", 64'(u_res), 64'(m_ru));
    chk("u_exception", 64'(u_exc), 64'(m_eu));
  end

  task automatic wait_rdy(output int n);
    n = 0;
    while (!s_rr && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic op(input logic [31:0] ia, input logic [31:0] ib, input logic im, input logic id,
                    input logic [31:0] er, input logic ee, input int el,
                    input bit cu, input logic [31:0] eur, input logic eue);
    int n;
    a = ia; b = ib; cm = im; cd = id;
    @(posedge clk); #1;
    cm = 0; cd = 0;
    wait_rdy(n);
    chk("lit_latency", 64'(n), 64'(el));
    chk("lit_s_result", 64'(s_res), 64'(er));
    chk("lit_s_exception", 64'(s_exc), 64'(ee));
    if (cu) begin
      chk("lit_u_result", 64'(u_res), 64'(eur));
      chk("lit_u_exception", 64'(u_exc), 64'(eue));
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'($signed($urandom_range(0, 200)) - 100);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    chk("rst_result", 64'(s_res), 64'h0);
    chk("rst_inputRDY", 64'(s_ir), 64'h1);
    chk("rst_resultRDY", 64'(s_rr), 64'h0);
    rst_n = 1'b1;
    op(32'd7, -32'sd6, 1, 0, 32'hFFFF_FFD6, 0, 33, 0, 0, 0);
    op(32'h0001_0000, 32'h0001_0000, 1, 0, 32'h0, 1, 33, 1, 32'h0, 1);
    op(32'h0000_FFFF, 32'h0000_FFFF, 1, 0, 32'hFFFE_0001, 1, 33, 1, 32'hFFFE_0001, 0);
    op(-32'sd7, 32'd2, 0, 1, 32'hFFFF_FFFD, 0, 33, 0, 0, 0);
    op(32'd5, 32'd0, 0, 1, 32'h0, 1, 1, 1, 32'h0, 1);
    op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, 1, 33, 1, 32'h0, 0);
    op(32'd3, 32'd4, 1, 1, 32'h0, 1, 1, 1, 32'h0, 1);
    // Start ignored while busy: a divide-by-zero pulse must not disturb the multiply.
    a = 32'd3; b = 32'd5; cm = 1;
    @(posedge clk); #1;
    cm = 0;
    repeat (4) @(posedge clk);
    #1;
    cd = 1; b = 32'd0;
    @(posedge clk); #1;
    cd = 0;
    wait_rdy(n);
    chk("busy_ignore_result", 64'(s_res), 64'd15);
    chk("busy_ignore_exception", 64'(s_exc), 64'h0);
    @(posedge clk); #1;
    // Reset in the middle of a multiply aborts it with no result pulse.
    a = 32'd9; b = 32'd9; cm = 1;
    @(posedge clk); #1;
    cm = 0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("abort_result", 64'(s_res), 64'h0);
    chk("abort_exception", 64'(s_exc), 64'h0);
    chk("abort_inputRDY", 64'(s_ir), 64'h1);
    chk("abort_resultRDY", 64'(s_rr), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    op(32'd7, -32'sd6, 1, 0, 32'hFFFF_FFD6, 0, 33, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      a = pick(); b = pick();
      cm = r < 2 || r == 4;
      cd = (r >= 2 && r < 4) || r == 4;
      @(posedge clk); #1;
    end
    cm = 0; cd = 0;
    repeat (40) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
